ks_sum_accumulator: RTL

//  Downstream consumer of the 16-bit Kogge-Stone adder. Takes its 17-bit Sum
//  (carry bit included) as a valid/ready stream and adds len consecutive sums

---
 rtl/ks_sum_accumulator.sv | 89 ++++++++
 1 files changed

// File: rtl/ks_sum_accumulator.sv
// Accumulates a run of len adder Sum words into a wide total with a sticky
// carry-out flag, and presents the result on a valid/ready port.
module ks_sum_accumulator #(
    parameter int SUM_W = 17,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] rem;
    logic             beat;
    logic [ACC_W:0]   sum;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign sum     = {1'b0, acc} + (ACC_W+1)'(in_sum);
    assign beat    = in_valid && in_ready;
    assign out_acc = acc;
    assign out_ovf = ovf;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (len == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && rem == CNT_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        rem <= len;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= sum[ACC_W-1:0];
                        ovf <= ovf | sum[ACC_W];
                        rem <= rem - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
